// File: rtl/instr_sequencer.sv
// Instruction phase sequencer: one-hot FETCH/DECODE/EXEC/WB phases, PC, memory handshake, beq resolution.
// Optional single-step start from IDLE via the `step` port when SEQ_SINGLE_STEP_EN is defined.
module instr_sequencer #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_INC   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic            step,
`endif
    input  logic            mem_ack,
    input  logic [6:0]      OpI,
    input  logic            zero,
    input  logic [PC_W-1:0] branch_off,
    output logic [7:0]      S,
    output logic [PC_W-1:0] PC,
    output logic            mem_req,
    output logic            halted,
    output logic [31:0]     instret
);

    localparam logic [6:0] OP_ADD = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    state_t          state, state_nxt;
    logic [6:0]      op_q;
    logic            op_is_mem;
    logic            start;

    function automatic logic op_legal(input logic [6:0] op);
        return (op == OP_ADD) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

    assign op_is_mem = (op_q == OP_LW) || (op_q == OP_SW);

`ifdef SEQ_SINGLE_STEP_EN
    assign start = run | step;
`else
    assign start = run;
`endif

    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        S         = 8'h00;
        mem_req   = 1'b0;
        halted    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                S       = 8'h01;
                mem_req = 1'b1;
                if (mem_ack) state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                S         = 8'h02;
                state_nxt = op_legal(OpI) ? ST_EXEC : ST_HALT;
            end
            ST_EXEC: begin
                S = 8'h04;
                if (op_is_mem) begin
                    mem_req = 1'b1;
                    if (mem_ack) state_nxt = ST_WB;
                end else begin
                    state_nxt = ST_WB;
                end
            end
            ST_WB: begin
                S         = 8'h08;
                state_nxt = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            PC      <= RESET_PC;
            instret <= '0;
            op_q    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_DECODE) op_q <= OpI;
            if (state == ST_WB) begin
                // Taken beq adds the signed offset; modulo-2^PC_W wrap is intended.
                if (op_q == OP_BEQ && zero) PC <= PC + branch_off;
                else                        PC <= PC + PC_W'(PC_INC);
                instret <= instret + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: vector table of instructions plus reset/halt/step corner cases.
module tb_instr_sequencer;

    localparam logic [6:0] OP_ADD = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step = 1'b0;
`endif
    logic        mem_ack = 1'b0;
    logic [6:0]  OpI = '0;
    logic        zero = 1'b0;
    logic [31:0] branch_off = '0;
    logic [7:0]  S;
    logic [31:0] PC;
    logic        mem_req;
    logic        halted;
    logic [31:0] instret;

    instr_sequencer #(.PC_W(32), .RESET_PC(32'h0), .PC_INC(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
`ifdef SEQ_SINGLE_STEP_EN
        .step       (step),
`endif
        .mem_ack    (mem_ack),
        .OpI        (OpI),
        .zero       (zero),
        .branch_off (branch_off),
        .S          (S),
        .PC         (PC),
        .mem_req    (mem_req),
        .halted     (halted),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        int          fw;        // cycles mem_ack is late in FETCH
        int          ew;        // cycles mem_ack is late in EXEC (lw/sw)
        logic        z;
        logic [31:0] off;
        logic [31:0] exp_pc;    // PC after this instruction retires
        logic [31:0] exp_ret;   // instret after this instruction retires
        bit          drop_run;  // drop run during DECODE
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ret;
    } sb_t;

    vec_t        tbl [10];
    sb_t         exp_q [$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] cur_pc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Entered with the DUT sampled in FETCH; leaves it just after the WB edge.
    task automatic exec_instr(input vec_t v);
        sb_t e;
        bit  is_mem;
        is_mem = (v.op == OP_LW) || (v.op == OP_SW);
        exp_q.push_back('{pc: v.exp_pc, ret: v.exp_ret});

        check("fetch_pc", PC, cur_pc);
        for (int i = 0; i < v.fw; i++) begin
            mem_ack = 1'b0;
            check("fetch_wait_S", S, 8'h01);
            check("fetch_wait_req", mem_req, 1'b1);
            tick();
        end
        mem_ack = 1'b1;
        check("fetch_S", S, 8'h01);
        check("fetch_req", mem_req, 1'b1);
        tick();

        mem_ack = 1'b0;
        OpI = v.op;
        check("decode_S", S, 8'h02);
        check("decode_req", mem_req, 1'b0);
        if (v.drop_run) run = 1'b0;
        tick();
        OpI = 7'h7f;

        if (is_mem) begin
            for (int i = 0; i < v.ew; i++) begin
                check("exec_wait_S", S, 8'h04);
                check("exec_wait_req", mem_req, 1'b1);
                tick();
            end
            mem_ack = 1'b1;
            check("exec_S", S, 8'h04);
            check("exec_req", mem_req, 1'b1);
            tick();
        end else begin
            mem_ack = 1'b1;
            check("exec_S", S, 8'h04);
            check("exec_req", mem_req, 1'b0);
            tick();
        end
        mem_ack = 1'b0;

        zero = v.z;
        branch_off = v.off;
        check("wb_S", S, 8'h08);
        check("wb_pc_old", PC, cur_pc);
        tick();
        zero = 1'b0;
        branch_off = 32'h0;

        e = exp_q.pop_front();
        check("retire_pc", PC, e.pc);
        check("retire_instret", instret, e.ret);
        check("after_wb_S", S, run ? 8'h01 : 8'h00);
        cur_pc = e.pc;
    endtask

    initial begin
        tbl[0] = '{OP_ADD, 0, 0, 1'b0, 32'h0,        32'h04, 32'd1, 1'b0};
        tbl[1] = '{OP_ADD, 0, 0, 1'b0, 32'h0,        32'h08, 32'd2, 1'b0};
        tbl[2] = '{OP_ADD, 0, 0, 1'b1, 32'h100,      32'h0C, 32'd3, 1'b0};
        tbl[3] = '{OP_LW,  0, 3, 1'b0, 32'h0,        32'h10, 32'd4, 1'b0};
        tbl[4] = '{OP_BEQ, 0, 0, 1'b1, 32'hFFFFFFF8, 32'h08, 32'd5, 1'b0};
        tbl[5] = '{OP_ADD, 2, 0, 1'b0, 32'h0,        32'h0C, 32'd6, 1'b0};
        tbl[6] = '{OP_SW,  1, 2, 1'b0, 32'h0,        32'h10, 32'd7, 1'b0};
        tbl[7] = '{OP_BEQ, 0, 0, 1'b0, 32'hFFFFFFF8, 32'h14, 32'd8, 1'b0};
        tbl[8] = '{OP_BEQ, 0, 0, 1'b1, 32'h10,       32'h24, 32'd9, 1'b0};
        tbl[9] = '{OP_ADD, 1, 0, 1'b0, 32'h0,        32'h28, 32'd10, 1'b1};

        do_reset();
        check("rst_S", S, 8'h00);
        check("rst_pc", PC, 32'h0);
        check("rst_req", mem_req, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_instret", instret, 32'h0);
        mem_ack = 1'b1;
        tick();
        check("idle_hold_S", S, 8'h00);
        check("idle_ack_ignored_req", mem_req, 1'b0);
        mem_ack = 1'b0;

        // Table run: back-to-back instructions, last one drops run mid-flight.
        cur_pc = 32'h0;
        run = 1'b1;
        tick();
        check("first_fetch_S", S, 8'h01);
        foreach (tbl[i]) exec_instr(tbl[i]);
        tick();
        check("idle_after_drop_S", S, 8'h00);
        check("idle_after_drop_pc", PC, 32'h28);

        // Illegal opcode: trap, sticky until reset.
        run = 1'b1;
        tick();
        check("halt_fetch_S", S, 8'h01);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        OpI = 7'b0010011;
        check("halt_decode_S", S, 8'h02);
        tick();
        check("halt_S", S, 8'h00);
        check("halt_flag", halted, 1'b1);
        check("halt_req", mem_req, 1'b0);
        check("halt_pc", PC, 32'h28);
        OpI = OP_ADD;
        mem_ack = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("halt_sticky_flag", halted, 1'b1);
        check("halt_sticky_S", S, 8'h00);
        check("halt_sticky_pc", PC, 32'h28);
        check("halt_instret", instret, 32'd10);
        mem_ack = 1'b0;
        run = 1'b0;
        do_reset();
        check("halt_clear_flag", halted, 1'b0);
        check("halt_clear_pc", PC, 32'h0);
        check("halt_clear_instret", instret, 32'h0);

        // Reset during a pending fetch; a late ack must not carry over.
        run = 1'b1;
        tick();
        tick();
        check("fetch_pend_req", mem_req, 1'b1);
        rst = 1'b1;
        run = 1'b0;
        tick();
        rst = 1'b0;
        check("rst_fetch_S", S, 8'h00);
        check("rst_fetch_pc", PC, 32'h0);
        check("rst_fetch_req", mem_req, 1'b0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("late_ack_S", S, 8'h00);
        run = 1'b1;
        tick();
        check("refetch_S", S, 8'h01);
        tick();
        check("refetch_wait_S", S, 8'h01);
        check("refetch_wait_req", mem_req, 1'b1);
        run = 1'b0;
        do_reset();

`ifdef SEQ_SINGLE_STEP_EN
        cur_pc = 32'h0;
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_fetch_S", S, 8'h01);
        exec_instr('{OP_ADD, 0, 0, 1'b0, 32'h0, 32'h04, 32'd1, 1'b0});
        tick();
        tick();
        check("step_idle_S", S, 8'h00);
        check("step_instret", instret, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

- Generates the one-hot phase vector `S` (fetch, decode, execute, writeback) that drives the main control FSM.
- Owns the program counter and handshakes with instruction/data memory through `mem_req`/`mem_ack`, stretching a phase until memory responds.
- Resolves `beq` branches at writeback and halts permanently on an unsupported opcode.

## Interface
- `PC_W`, 32: program counter width.
- `RESET_PC`, 0: PC value after reset.
- `PC_INC`, 4: sequential PC increment.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `run`  in  1  level; 1 = execute continuously, 0 = stop at next instruction boundary.
- `mem_ack`  in  1  memory completion, sampled only while `mem_req`=1.
- `OpI`  in  7  opcode of current instruction, valid during DECODE.
- `zero`  in  1  ALU zero flag, valid during WB.
- `branch_off`  in  PC_W  signed byte offset for `beq`, valid during WB.
- `S`  out  8  one-hot phase: 0x01 FETCH, 0x02 DECODE, 0x04 EXEC, 0x08 WB, 0x00 IDLE/HALT.
- `PC`  out  PC_W  address of current instruction.
- `mem_req`  out  1  memory access request.
- `halted`  out  1  illegal opcode trap, sticky.
- `instret`  out  32  retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT. `S` is a direct decode of the state register.
- Reset values: state IDLE, `S`=0x00, `PC`=RESET_PC, `mem_req`=0, `halted`=0, `instret`=0, latched opcode=0.
- IDLE → FETCH when `run`=1; otherwise stays in IDLE.
- FETCH: `mem_req`=1. Stay until `mem_ack`=1, then → DECODE.
- DECODE: latch `OpI` into `op_q`; later changes to `OpI` are ignored.
  - `op_q` legal: 0110011 add, 0000011 lw, 0100011 sw, 1100011 beq → EXEC.
  - Any other opcode → HALT.
- EXEC:
  - lw/sw: `mem_req`=1, stay until `mem_ack`=1, then → WB.
  - add/beq: one cycle, then → WB.
- WB:
  - `PC` ← `PC`+`branch_off` if `op_q`=beq and `zero`=1; otherwise `PC` ← `PC`+PC_INC.
  - Arithmetic is modulo 2^PC_W; wrap-around is silent.
  - `instret` increments, wrapping at 2^32.
  - Next state FETCH if `run`=1, else IDLE.
- HALT: `halted`=1, `S`=0x00, `mem_req`=0, `PC` frozen at the faulting instruction. Only `rst` exits.
- `mem_req` is a combinational decode of state plus `op_q` (no extra register).
- `mem_ack` asserted while `mem_req`=0 is ignored.

## Timing
- Zero-wait instruction with `mem_ack` high in the same cycle as the request:
  - add/beq: 4 cycles (FETCH, DECODE, EXEC, WB).
  - lw/sw: 4 cycles.
- Each cycle `mem_ack` is late adds one cycle to FETCH or EXEC.
- `PC` and `instret` update on the clock edge that leaves WB; the new values are visible in the next FETCH.
- First FETCH occurs the cycle after `run` is sampled high in IDLE.
- `run` dropping mid-instruction: the instruction completes through WB, then IDLE.
- `rst` mid-operation, including during a pending `mem_req`:
  - Overrides all transitions; next cycle is IDLE with reset values.
  - A pending access is abandoned; a late `mem_ack` is ignored.

## Configuration
- `SEQ_SINGLE_STEP_EN` defined:
  - Adds input port `step` (1 bit).
  - In IDLE with `run`=0, `step`=1 starts exactly one instruction, which returns to IDLE after WB.
  - Holding `step` high repeats one instruction per pass through IDLE.
  - `run`=1 behaves as without the macro.
- Undefined: no `step` port; IDLE exits only on `run`=1.

## Test plan
- Reset, then `run`=1, `OpI`=0110011, `mem_ack` tied 1:
  - `S` sequence 0x01,0x02,0x04,0x08 repeating.
  - `PC` 0,4,8; `instret` +1 per 4 cycles.
- lw (`OpI`=0000011) with `mem_ack` delayed 3 cycles in EXEC:
  - `S`=0x04 held 4 cycles with `mem_req`=1.
  - Instruction takes 7 cycles; `PC` +4.
- beq, `zero`=1, `branch_off`=0xFFFFFFF8, `PC`=0x10 → next `PC`=0x08.
  - Same with `zero`=0 → `PC`=0x14.
- `OpI`=0010011 in DECODE:
  - HALT: `halted`=1, `S`=0x00, `mem_req`=0, `PC` unchanged.
  - Persists until `rst`=1.
- `rst` asserted during FETCH wait:
  - Next cycle `S`=0x00, `PC`=RESET_PC, `mem_req`=0.
  - A late `mem_ack` pulse is ignored.
- `SEQ_SINGLE_STEP_EN`, `run`=0, one-cycle `step` pulse:
  - Exactly one instruction executes, then IDLE.
  - `instret` = 1.
